// File: rtl/udl_count_arbiter.sv
// Shared n-bit up/down/load counter serving NREQ requesters through a
// round-robin arbiter that commits at most one operation per clock.
module udl_count_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned n    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [n*NREQ-1:0] ld_data,
    output logic [NREQ-1:0]   gnt,
    output logic [n-1:0]      rd_data,
    output logic [NREQ-1:0]   ack,
    output logic [n-1:0]      count,
    output logic              ovf,
    output logic              unf
);

    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;
    logic          grant;
    int unsigned   sel;
    int unsigned   cand;
    op_e           sel_op;
    logic [n-1:0]  sel_ld;
    logic [n-1:0]  count_next;
    logic          wrap_up;
    logic          wrap_down;

    // First set request at or above ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = 0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        grant      = found && en && !rst;
        gnt        = grant ? (NREQ'(1) << sel) : '0;
        sel_op     = op_e'(op[2*sel +: 2]);
        sel_ld     = ld_data[n*sel +: n];
        ptr_next   = (sel == NREQ - 1) ? '0 : PW'(sel + 1);
        count_next = count;
        wrap_up    = 1'b0;
        wrap_down  = 1'b0;
        case (sel_op)
            OP_UP: begin
                count_next = count + 1'b1;
                wrap_up    = (count == '1);
            end
            OP_DOWN: begin
                count_next = count - 1'b1;
                wrap_down  = (count == '0);
            end
            OP_LOAD: count_next = sel_ld;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            rd_data <= '0;
            ack     <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            ptr     <= '0;
        end else if (grant) begin
            count   <= count_next;
            rd_data <= count_next;
            ack     <= gnt;
            ovf     <= wrap_up;
            unf     <= wrap_down;
            ptr     <= ptr_next;
        end else begin
            ack <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udl_count_arbiter.sv
// Scoreboard bench for udl_count_arbiter: the driver pushes hand-computed
// responses per grant, a negedge monitor pops and compares on every ack.
module tb_udl_count_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [15:0] ld_data;
    logic [3:0]  gnt;
    logic [3:0]  rd_data;
    logic [3:0]  ack;
    logic [3:0]  count;
    logic        ovf;
    logic        unf;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic mon_on  = 1'b0;

    udl_count_arbiter #(.NREQ(4), .n(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .op      (op),
        .ld_data (ld_data),
        .gnt     (gnt),
        .rd_data (rd_data),
        .ack     (ack),
        .count   (count),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // One request cycle: drive, check the combinational grant, queue the response.
    task automatic cyc(input string name, input logic e, input logic [3:0] r,
                       input logic [7:0] o, input logic [15:0] ld,
                       input logic [3:0] eg, input logic [3:0] ec,
                       input logic eo, input logic eu);
        exp_t x;
        en = e; req = r; op = o; ld_data = ld;
        #1;
        check({name, "_gnt"}, {12'h0, gnt}, {12'h0, eg});
        if (eg != 4'b0000) begin
            x.ack = eg; x.cnt = ec; x.ovf = eo; x.unf = eu;
            exp_q.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (ack != 4'b0000) begin
                exp_t x;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_ack: got ack=%b count=%h", ack, count);
                end else begin
                    x = exp_q.pop_front();
                    if (ack === x.ack && count === x.cnt && rd_data === x.cnt &&
                        ovf === x.ovf && unf === x.unf)
                        n_pass++;
                    else
                        $display("FAIL resp: got ack=%b count=%h rd=%h ovf=%b unf=%b expected ack=%b count=%h rd=%h ovf=%b unf=%b",
                                 ack, count, rd_data, ovf, unf, x.ack, x.cnt, x.cnt, x.ovf, x.unf);
                end
            end else begin
                n_total++;
                if (ovf === 1'b0 && unf === 1'b0) n_pass++;
                else $display("FAIL idle_flags: got ovf=%b unf=%b expected 0 0", ovf, unf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; req = 4'b1111; op = 8'h00; ld_data = 16'h0000;
        #1;
        check("rst_gnt", {12'h0, gnt}, 16'h0000);
        @(posedge clk); #1;
        check("rst_gnt2", {12'h0, gnt}, 16'h0000);
        check("rst_count", {12'h0, count}, 16'h0000);
        check("rst_rd", {12'h0, rd_data}, 16'h0000);
        check("rst_ack", {12'h0, ack}, 16'h0000);
        check("rst_flags", {14'h0, ovf, unf}, 16'h0000);
        mon_on = 1'b1;
        rst = 1'b0;

        // Round robin, all up: counts 1..8.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] g;
            g = 4'b0001 << (i % 4);
            cyc("rr", 1'b1, 4'b1111, 8'b01010101, 16'h0000, g, 4'(i + 1), 1'b0, 1'b0);
        end

        // Wrap: load F, up -> 0 ovf, down -> F unf.
        cyc("ld_f", 1'b1, 4'b0001, 8'b00000011, 16'h000F, 4'b0001, 4'hF, 1'b0, 1'b0);
        cyc("ovf",  1'b1, 4'b0010, 8'b00000100, 16'h0000, 4'b0010, 4'h0, 1'b1, 1'b0);
        cyc("unf",  1'b1, 4'b0100, 8'b00100000, 16'h0000, 4'b0100, 4'hF, 1'b0, 1'b1);

        // Walk ptr to 2, then collide req0/req1.
        cyc("rd3",  1'b1, 4'b1000, 8'h00, 16'h0000, 4'b1000, 4'hF, 1'b0, 1'b0);
        cyc("rd1",  1'b1, 4'b0010, 8'h00, 16'h0000, 4'b0010, 4'hF, 1'b0, 1'b0);
        cyc("col0", 1'b1, 4'b0011, 8'h00, 16'h0000, 4'b0001, 4'hF, 1'b0, 1'b0);
        cyc("col1", 1'b1, 4'b0010, 8'h00, 16'h0000, 4'b0010, 4'hF, 1'b0, 1'b0);

        // Load A from req3, then read from req0.
        cyc("ld_a", 1'b1, 4'b1000, 8'b11000000, 16'hA000, 4'b1000, 4'hA, 1'b0, 1'b0);
        cyc("read", 1'b1, 4'b0001, 8'h00, 16'h0000, 4'b0001, 4'hA, 1'b0, 1'b0);

        // Enable low for 3 cycles: no grants, count holds, ptr stays 1.
        for (int i = 0; i < 3; i++)
            cyc("en_lo", 1'b0, 4'b1111, 8'b01010101, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        check("en_lo_count", {12'h0, count}, 16'h000A);
        cyc("en_b", 1'b1, 4'b1111, 8'b01010101, 16'h0000, 4'b0010, 4'hB, 1'b0, 1'b0);
        cyc("en_c", 1'b1, 4'b1111, 8'b01010101, 16'h0000, 4'b0100, 4'hC, 1'b0, 1'b0);

        // Reset coincident with a pending grant.
        rst = 1'b1;
        cyc("rst_mid", 1'b1, 4'b1111, 8'b01010101, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        check("rst_mid_count", {12'h0, count}, 16'h0000);
        check("rst_mid_ack", {12'h0, ack}, 16'h0000);
        rst = 1'b0;
        cyc("post_rst", 1'b1, 4'b1111, 8'b01010101, 16'h0000, 4'b0001, 4'h1, 1'b0, 1'b0);
        cyc("idle", 1'b1, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("queue_empty", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/udl_count_arbiter.md
Name: udl_count_arbiter

Overview:
- Shares a single n-bit up/down/load counter among NREQ requesters.
- Each requester posts one operation (up, down, load or read) with a req/gnt handshake. A round-robin arbiter commits at most one operation per clock.
- Used wherever several agents adjust a common count, such as credit pools, shared occupancy counters or event tallies.
- The counter state lives inside this block and is exported on count.

Parameters:
- NREQ, 4, number of requesters (2..8).
- n, 4, counter width in bits (1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global enable; 0 blocks all grants.
- req  input  NREQ  per-requester request, level, held until granted.
- op  input  2*NREQ  per-requester op, requester i owns bits [2i+1:2i]. Encoding: 00 read, 01 up, 10 down, 11 load.
- ld_data  input  n*NREQ  per-requester load value, requester i owns bits [n*i+n-1:n*i].
- gnt  output  NREQ  one-hot combinational grant.
- rd_data  output  n  registered count value captured for the last granted op (post-op value).
- ack  output  NREQ  registered one-hot pulse, one cycle after the grant cycle.
- count  output  n  registered counter value.
- ovf  output  1  registered one-cycle pulse: up wrapped all-ones -> 0.
- unf  output  1  registered one-cycle pulse: down wrapped 0 -> all-ones.

Behaviour:
- Reset, sync, rst=1 at an edge: count=0, rd_data=0, ack=0, ovf=0, unf=0, rr pointer=0. gnt is forced to 0 while rst=1.
- rst has priority over every other input. A request pending at reset is dropped silently and gets no ack; the requester must keep req high to be served after reset.
- Arbitration (combinational):
  - When en=1 and req!=0, gnt selects the first set req bit searching from ptr upward, modulo NREQ.
  - When en=0 or req=0, gnt=0.
- Commit at the edge where gnt[i]=1, using op_i:
  - 01: count <= count+1, modulo 2^n.
  - 10: count <= count-1, modulo 2^n.
  - 11: count <= ld_data_i.
  - 00: count unchanged.
- At the same commit edge:
  - rd_data <= new count value.
  - ack <= one-hot i.
  - ptr <= (i+1) mod NREQ.
- Edge with no grant: count, rd_data and ptr hold; ack, ovf and unf clear to 0.
- Latency:
  - Grant is visible in the request cycle.
  - The updated count and ack are visible in the next cycle, 1-cycle latency.
  - Throughput is one op per clock in total across all requesters.
- Handshake:
  - The requester samples gnt at the edge. If gnt[i]=1, the op is consumed.
  - The requester either drops req or presents a new op with req held; back-to-back is legal.
  - A requester keeping req=1 after a grant is treated as a new request and competes again at lower priority.
  - op and ld_data must be stable while req=1 and not granted; changes before grant are undefined.
- Wrap flags:
  - ovf=1 for one cycle after an up commit from 2^n-1.
  - unf=1 for one cycle after a down commit from 0.
  - A load never sets a flag, even when loading from or to the boundary.
- Fairness: with all NREQ requesting continuously, each is granted exactly once every NREQ cycles.
- en deasserted mid-stream: no commits occur and ptr holds. Arbitration resumes from the same ptr when en returns to 1.

Test Plan:
- Reset: assert rst with req=4'b1111 → gnt=0. After the edge, count=0, ack=0 and ovf=unf=0. On the first cycle after rst drops, gnt=4'b0001.
- Round-robin: all four req held with op=01 for 8 cycles → gnt sequence 0001,0010,0100,1000 repeated twice. count reads 1..8 one cycle after each grant, with the matching ack pulses.
- Wrap (n=4): req0 loads 4'hF. Next cycle req1 does up → count=0 and ovf=1 for exactly one cycle. Then req2 does down → count=4'hF and unf=1.
- Collision and priority: ptr=2 with req=4'b0011 → gnt=0001. Next cycle, req1 still held → gnt=0010.
- Load/read: req3 op=11 with ld_data=4'hA → count=A and rd_data=A. Then req0 op=00 → count stays A, rd_data=A and ack=0001.
- Enable/reset mid-stream: drop en for 3 cycles with all req high → no acks and count unchanged. Restore en → grants continue from the prior ptr. Assert rst in the same cycle as a grant → count=0 and no ack.
